// File: rtl/decoder_pkg.sv
// Shared layout constants, state encoding and helpers for the instruction decoder.
package decoder_pkg;

   localparam int DEF_BUS_WIDTH    = 33;
   localparam int DEF_OPCODE_WIDTH = 5;
   localparam int DEF_ADDR_WIDTH   = 5;
   localparam int DEF_FIFO_DEPTH   = 2;

   // Instruction layout, MSB first: opcode, rd, rs, sel, imm.
   localparam int IMM_WIDTH = DEF_BUS_WIDTH - DEF_OPCODE_WIDTH - 2*DEF_ADDR_WIDTH - 1;
   localparam int OPC_MSB   = DEF_BUS_WIDTH - 1;
   localparam int RD_MSB    = OPC_MSB - DEF_OPCODE_WIDTH;
   localparam int RS_MSB    = RD_MSB - DEF_ADDR_WIDTH;
   localparam int SEL_BIT   = RS_MSB - DEF_ADDR_WIDTH;
   localparam int IMM_MSB   = SEL_BIT - 1;

   localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_NOP = '0;

   typedef enum logic {IDLE, ISSUE} state_e;

   function automatic logic [DEF_BUS_WIDTH-1:0] sign_extend(input logic [IMM_WIDTH-1:0] imm);
      return {{(DEF_BUS_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   endfunction

endpackage

// File: rtl/decoder_fifo.sv
// Small synchronous FIFO buffering packed instructions ahead of the decoder.
module decoder_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for a push.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_decoder.sv
// Buffers incoming instructions, decodes one at a time and holds it until execute echoes its opcode.
module instr_decoder
   import decoder_pkg::*;
#(
   parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
   parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   input  logic [BUS_WIDTH-1:0]    instr,
   input  logic [OPCODE_WIDTH-1:0] op_done,
   input  logic                    next_instr,
   output logic [BUS_WIDTH-1:0]    imme_value,
   output logic [OPCODE_WIDTH-1:0] opcode,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [ADDR_WIDTH-1:0]   rs_addr,
   output logic                    rs_addr_sel,
   output logic                    rs_addr_valid,
   output logic                    fifo_full,
   output logic                    overflow
);

   localparam int IMM_W   = BUS_WIDTH - OPCODE_WIDTH - 2*ADDR_WIDTH - 1;
   localparam int RD_TOP  = BUS_WIDTH - OPCODE_WIDTH - 1;
   localparam int RS_TOP  = RD_TOP - ADDR_WIDTH;
   localparam int SEL_POS = RS_TOP - ADDR_WIDTH;

   state_e                  state;
   logic [BUS_WIDTH-1:0]    head;
   logic [OPCODE_WIDTH-1:0] head_opc;
   logic                    fifo_empty;
   logic                    complete;
   logic                    pop;

   assign head_opc = head[BUS_WIDTH-1 -: OPCODE_WIDTH];
   assign complete = (state == ISSUE) && (op_done == opcode);
   assign pop      = !fifo_empty && next_instr && ((state == IDLE) || complete);

   decoder_fifo #(
      .WIDTH (BUS_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (instr_valid),
      .pop   (pop),
      .wdata (instr),
      .full  (fifo_full),
      .empty (fifo_empty),
      .rdata (head)
   );

   // A completing instruction hands straight over to the next entry; a popped NOP just falls back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         opcode        <= '0;
         rd_addr       <= '0;
         rs_addr       <= '0;
         rs_addr_sel   <= 1'b0;
         rs_addr_valid <= 1'b0;
         imme_value    <= '0;
         overflow      <= 1'b0;
      end else begin
         if (instr_valid && fifo_full) overflow <= 1'b1;

         if (pop && (head_opc != OPC_NOP)) begin
            state         <= ISSUE;
            opcode        <= head_opc;
            rd_addr       <= head[RD_TOP -: ADDR_WIDTH];
            rs_addr       <= head[RS_TOP -: ADDR_WIDTH];
            rs_addr_sel   <= head[SEL_POS];
            rs_addr_valid <= head[SEL_POS];
            imme_value    <= sign_extend(head[IMM_W-1:0]);
         end else if (pop || complete) begin
            state         <= IDLE;
            opcode        <= '0;
            rd_addr       <= '0;
            rs_addr       <= '0;
            rs_addr_sel   <= 1'b0;
            rs_addr_valid <= 1'b0;
            imme_value    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed vector table for the decoder corner cases followed by randomized traffic against a queue-based model.
module tb_instr_decoder;

   typedef struct {
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic        sel;
      logic        rs_valid;
      logic [32:0] imm;
      logic        full;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [32:0] instr;
      logic [4:0]  op_done;
      logic        next;
      exp_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [32:0] instr = '0;
   logic [4:0]  op_done = '0;
   logic        next_instr = 1'b0;
   logic [32:0] imme_value;
   logic [4:0]  opcode;
   logic [4:0]  rd_addr;
   logic [4:0]  rs_addr;
   logic        rs_addr_sel;
   logic        rs_addr_valid;
   logic        fifo_full;
   logic        overflow;

   int compared = 0;
   int mismatched = 0;
   vec_t vecs[$];

   // Model state: buffered words, the instruction being issued, sticky drop flag.
   logic [32:0] mq[$];
   logic [32:0] m_cur;
   bit          m_busy;
   bit          m_ovf;

   instr_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .op_done       (op_done),
      .next_instr    (next_instr),
      .imme_value    (imme_value),
      .opcode        (opcode),
      .rd_addr       (rd_addr),
      .rs_addr       (rs_addr),
      .rs_addr_sel   (rs_addr_sel),
      .rs_addr_valid (rs_addr_valid),
      .fifo_full     (fifo_full),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] mk(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic sel, input logic [16:0] imm);
      return {opc, rd, rs, sel, imm};
   endfunction

   function automatic exp_t expIssue(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic sel, input logic [32:0] imm, input logic full, input logic ovf);
      exp_t e;
      e.opcode = opc; e.rd = rd; e.rs = rs; e.sel = sel; e.rs_valid = sel;
      e.imm = imm; e.full = full; e.ovf = ovf;
      return e;
   endfunction

   function automatic exp_t expIdle(input logic full, input logic ovf);
      return expIssue(5'd0, 5'd0, 5'd0, 1'b0, 33'd0, full, ovf);
   endfunction

   task automatic addVec(input logic r, input logic v, input logic [32:0] ins, input logic [4:0] opd,
                         input logic nx, input exp_t e);
      vec_t t;
      t.rst = r; t.valid = v; t.instr = ins; t.op_done = opd; t.next = nx; t.exp = e;
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [32:0] ins,
                                input logic [4:0] opd, input logic nx);
      rst = r; instr_valid = v; instr = ins; op_done = opd; next_instr = nx;
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string tag, input string field, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s.%s got %0h expected %0h", tag, field, got, want);
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e);
      checkField(tag, "opcode", 64'(opcode), 64'(e.opcode));
      checkField(tag, "rd_addr", 64'(rd_addr), 64'(e.rd));
      checkField(tag, "rs_addr", 64'(rs_addr), 64'(e.rs));
      checkField(tag, "rs_addr_sel", 64'(rs_addr_sel), 64'(e.sel));
      checkField(tag, "rs_addr_valid", 64'(rs_addr_valid), 64'(e.rs_valid));
      checkField(tag, "imme_value", 64'(imme_value), 64'(e.imm));
      checkField(tag, "fifo_full", 64'(fifo_full), 64'(e.full));
      checkField(tag, "overflow", 64'(overflow), 64'(e.ovf));
   endtask

   // One clock of the reference behaviour, evaluated on the state before the edge.
   function automatic void modelStep(input logic r, input logic v, input logic [32:0] ins,
                                     input logic [4:0] opd, input logic nx);
      bit was_full = (mq.size() == 2);
      bit done     = m_busy && (33'(opd) == (m_cur >> 28));
      bit popping  = (mq.size() != 0) && nx && (!m_busy || done);
      logic [32:0] w;
      if (r) begin
         mq.delete();
         m_busy = 0;
         m_ovf  = 0;
         m_cur  = '0;
         return;
      end
      if (popping) begin
         w = mq.pop_front();
         m_busy = ((w >> 28) != 0);
         if (m_busy) m_cur = w;
      end else if (done) begin
         m_busy = 0;
      end
      if (v) begin
         if (was_full) m_ovf = 1;
         else mq.push_back(ins);
      end
   endfunction

   function automatic exp_t modelExp();
      longint imm17;
      longint sx;
      logic [32:0] imm33;
      logic full = (mq.size() == 2);
      if (!m_busy) return expIdle(full, m_ovf);
      imm17 = longint'(m_cur % 33'd131072);
      sx    = (imm17 >= 65536) ? imm17 - 131072 : imm17;
      imm33 = sx[32:0];
      return expIssue(5'((m_cur >> 28) % 32), 5'((m_cur >> 23) % 32), 5'((m_cur >> 18) % 32),
                      1'((m_cur >> 17) % 2), imm33, full, m_ovf);
   endfunction

   initial begin
      logic [32:0] a, b, c, d, e, f, g, n0, i9, j, k;
      logic        r, v, nx;
      logic [32:0] ins;
      logic [4:0]  opd;

      a  = mk(5'd3, 5'd7, 5'd12, 1'b1, 17'h1FFFF);
      b  = mk(5'd5, 5'd2, 5'd0, 1'b0, 17'h00010);
      c  = mk(5'd4, 5'd1, 5'd2, 1'b1, 17'h00000);
      d  = mk(5'd6, 5'd3, 5'd4, 1'b0, 17'h10000);
      e  = mk(5'd8, 5'd5, 5'd6, 1'b1, 17'h00005);
      f  = mk(5'd10, 5'd9, 5'd11, 1'b0, 17'h0FFFF);
      g  = mk(5'd12, 5'd13, 5'd14, 1'b1, 17'h00001);
      n0 = mk(5'd0, 5'd1, 5'd1, 1'b1, 17'h00001);
      i9 = mk(5'd9, 5'd4, 5'd5, 1'b1, 17'h00003);
      j  = mk(5'd7, 5'd6, 5'd8, 1'b1, 17'h00002);
      k  = mk(5'd11, 5'd10, 5'd3, 1'b0, 17'h00007);

      addVec(1, 0, '0, 0, 0, expIdle(0, 0));
      // Basic decode: visible two edges after the push, held until op_done matches.
      addVec(0, 1, a, 0, 1, expIdle(0, 0));
      addVec(0, 0, '0, 0, 1, expIssue(3, 7, 12, 1, 33'h1_FFFF_FFFF, 0, 0));
      addVec(0, 0, '0, 0, 1, expIssue(3, 7, 12, 1, 33'h1_FFFF_FFFF, 0, 0));
      addVec(0, 0, '0, 3, 1, expIdle(0, 0));
      // Immediate form with a non-matching completion tag.
      addVec(0, 1, b, 0, 1, expIdle(0, 0));
      addVec(0, 0, '0, 0, 1, expIssue(5, 2, 0, 0, 33'd16, 0, 0));
      addVec(0, 0, '0, 3, 1, expIssue(5, 2, 0, 0, 33'd16, 0, 0));
      addVec(0, 0, '0, 5, 1, expIdle(0, 0));
      // Back-to-back handover with no idle cycle.
      addVec(0, 1, c, 0, 1, expIdle(0, 0));
      addVec(0, 1, d, 0, 1, expIssue(4, 1, 2, 1, 33'd0, 0, 0));
      addVec(0, 0, '0, 4, 1, expIssue(6, 3, 4, 0, 33'h1_FFFF_0000, 0, 0));
      addVec(0, 0, '0, 6, 1, expIdle(0, 0));
      // Stall fills the FIFO; the third push meets a same-cycle pop and is still dropped.
      addVec(0, 1, e, 0, 0, expIdle(0, 0));
      addVec(0, 1, f, 0, 0, expIdle(1, 0));
      addVec(0, 1, g, 0, 1, expIssue(8, 5, 6, 1, 33'd5, 0, 1));
      addVec(0, 0, '0, 0, 1, expIssue(8, 5, 6, 1, 33'd5, 0, 1));
      addVec(0, 0, '0, 8, 1, expIssue(10, 9, 11, 0, 33'h0_0000_FFFF, 0, 1));
      addVec(0, 0, '0, 10, 1, expIdle(0, 1));
      addVec(0, 0, '0, 0, 1, expIdle(0, 1));
      // NOP is consumed silently.
      addVec(0, 1, n0, 0, 1, expIdle(0, 1));
      addVec(0, 1, i9, 0, 1, expIdle(0, 1));
      addVec(0, 0, '0, 0, 1, expIssue(9, 4, 5, 1, 33'd3, 0, 1));
      addVec(0, 0, '0, 9, 1, expIdle(0, 1));
      // Reset while issuing discards the held and buffered instructions.
      addVec(0, 1, j, 0, 1, expIdle(0, 1));
      addVec(0, 1, k, 0, 1, expIssue(7, 6, 8, 1, 33'd2, 0, 1));
      addVec(1, 0, '0, 0, 1, expIdle(0, 0));
      addVec(0, 0, '0, 0, 1, expIdle(0, 0));
      addVec(0, 0, '0, 11, 1, expIdle(0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].instr, vecs[i].op_done, vecs[i].next);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      mq.delete();
      m_busy = 0;
      m_ovf  = 0;
      m_cur  = '0;
      for (int i = 0; i < 1500; i++) begin
         r   = (i == 0) || ($urandom_range(0, 99) == 0);
         v   = $urandom_range(0, 1) == 1;
         ins = {5'($urandom_range(0, 7)), 28'($urandom)};
         nx  = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 2) == 0) opd = 5'((m_cur >> 28) % 32);
         else opd = 5'($urandom_range(0, 8));
         modelStep(r, v, ins, opd, nx);
         applyStimulus(r, v, ins, opd, nx);
         checkOutput($sformatf("rand%0d", i), modelExp());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Consumer end of the decoder_if protocol. Accepts packed instructions from the upstream driver into a small input FIFO.
- Each entry is popped, split into fields and sign-extended, then presented on registered outputs.
- The decoded instruction is held until the execute stage echoes its opcode on op_done.
- Sits between instruction fetch and the execute/register-file stage.

Parameters:
- BUS_WIDTH, 33, instruction and immediate width
- OPCODE_WIDTH, 5, opcode field and op_done width
- ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 2, input buffer entries (power of two, >=2)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instr is valid this cycle
- instr  input  BUS_WIDTH  packed instruction
- op_done  input  OPCODE_WIDTH  completion tag from execute; 0 = none
- next_instr  input  1  upstream permits advancing to next buffered instruction
- imme_value  output  BUS_WIDTH  sign-extended immediate
- opcode  output  OPCODE_WIDTH  decoded opcode; 0 = NOP/idle
- rd_addr  output  ADDR_WIDTH  destination register
- rs_addr  output  ADDR_WIDTH  source register
- rs_addr_sel  output  1  1 = register operand, 0 = immediate operand
- rs_addr_valid  output  1  rs_addr is live (ISSUE state and rs_addr_sel=1)
- fifo_full  output  1  FIFO count == FIFO_DEPTH
- overflow  output  1  sticky: an instruction was dropped

Behaviour:
- Field layout, MSB first:
  - opcode [BUS_WIDTH-1 -: OPCODE_WIDTH]
  - rd, then rs, each ADDR_WIDTH
  - sel, 1 bit
  - imm, IMM_WIDTH = BUS_WIDTH-OPCODE_WIDTH-2*ADDR_WIDTH-1 (17 at defaults)
- imme_value = imm sign-extended from its MSB to BUS_WIDTH.
- Reset:
  - all outputs 0, FIFO emptied, overflow cleared, state IDLE.
  - Applies mid-ISSUE too; the in-flight instruction is discarded.
- Push:
  - instr_valid=1 and FIFO not full: write at the edge.
  - instr_valid=1 and FIFO full: instr dropped, overflow set at the edge, held until rst.
  - A same-cycle pop does not unblock a push while full.
- Pop condition: FIFO non-empty, next_instr=1, and (state IDLE or ISSUE completing this cycle).
- FSM, states IDLE and ISSUE:
  - IDLE: all decode outputs 0. On pop of a non-NOP entry: register fields, go to ISSUE. On pop of an opcode-0 entry: consume it and stay IDLE (NOP skipped, outputs stay 0).
  - ISSUE: outputs held stable. Completion = op_done == opcode; op_done of 0 or non-matching is ignored.
  - On completion with a pop possible: load the next entry in the same edge (zero bubble; NOP next goes to IDLE).
  - Otherwise on completion: go to IDLE and zero outputs.
- Latency: instr_valid at cycle N into an empty FIFO in IDLE with next_instr=1 gives outputs valid in cycle N+2 (write at edge N, load at edge N+1). No write-to-read bypass.
- next_instr=0 stalls pops only; pushes continue.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; count has one extra bit.

Decomposition:
- decoder_pkg holds:
  - field position/width localparams derived from the parameters
  - OPC_NOP = '0
  - state_e {IDLE, ISSUE}
  - a sign-extension function
- One sub-module, decoder_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/wdata/rdata, rdata registered from head.

Test Plan:
- Basic decode: push {opc=3, rd=7, rs=12, sel=1, imm=17'h1FFFF} with next_instr=1 -> cycle N+2 shows opcode=3, rd_addr=7, rs_addr=12, rs_addr_sel=1, rs_addr_valid=1, imme_value=33'h1_FFFF_FFFF. Outputs held until op_done=3, then all 0 next cycle.
- Immediate form: push {opc=5, rd=2, sel=0, imm=17'h00010} -> imme_value=16, rs_addr_valid=0. op_done=3 is ignored (still ISSUE); op_done=5 completes.
- Back-to-back: two instructions buffered (opc 4, then 6); op_done=4 with next_instr=1 -> opcode=6 on the very next cycle, no zero cycle.
- Overflow/stall: next_instr=0, push 3 instructions (FIFO_DEPTH=2) -> fifo_full=1 after 2; third dropped, overflow=1. Raise next_instr -> the 2 retained issue in order; overflow stays 1 until rst.
- NOP skip: push opc=0, then opc=9 -> opc 0 never appears on outputs; opcode=9 issued one cycle after the NOP pop.
- Reset mid-ISSUE: rst=1 for 1 cycle while opcode=7 is held and the FIFO holds 1 entry -> next cycle all outputs 0, fifo_full=0, and the old entry never issues.
